// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache -- direct-mapped, one-word-per-frame instruction cache.
//
// Sits between the datapath instruction port and the memory-side read port.
// A hit is answered combinationally in the same cycle. A miss latches the
// word address, enters FETCH, and holds ram_iREN/ram_iaddr until the memory
// drops ram_iwait. The returned word is then written into the frame and the
// cache goes back to IDLE, where the current request is evaluated again.
//
// Parameters
//   NSETS    number of frames (power of two, 2..256)
//   PC_INIT  first fetch address after reset; informational only
//
// Ports
//   CLK, RST     rising-edge clock, synchronous active-high reset
//   dp_imemREN   datapath read request
//   dp_imemaddr  datapath byte address (bits [1:0] ignored)
//   dp_ihit      dp_imemload holds the requested word this cycle
//   dp_imemload  instruction word (zero when dp_ihit is low)
//   ram_iREN     memory read request (high for every FETCH cycle)
//   ram_iaddr    word-aligned miss address (zero in IDLE)
//   ram_iwait    memory busy
//   ram_iload    memory read data
//   hit_count    saturating count of IDLE hit cycles
//   miss_count   saturating count of IDLE->FETCH transitions
// ---------------------------------------------------------------------------
module icache #(
  parameter int unsigned NSETS   = 16,
  parameter logic [31:0] PC_INIT = '0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dp_imemREN,
  input  logic [31:0] dp_imemaddr,
  output logic        dp_ihit,
  output logic [31:0] dp_imemload,
  output logic        ram_iREN,
  output logic [31:0] ram_iaddr,
  input  logic        ram_iwait,
  input  logic [31:0] ram_iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX_W = $clog2(NSETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state;
  logic [NSETS-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [NSETS];
  logic [31:0]       data_mem [NSETS];
  logic [29:0]       miss_waddr;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic              hit;
  logic              miss;
  logic              fill;
  logic              unused_addr_lsbs;

  assign req_idx  = dp_imemaddr[2 +: IDX_W];
  assign req_tag  = dp_imemaddr[31 -: TAG_W];
  assign miss_idx = miss_waddr[IDX_W-1:0];
  assign miss_tag = miss_waddr[29 -: TAG_W];

  assign unused_addr_lsbs = ^dp_imemaddr[1:0];

  // valid gates the comparison so uninitialised tags never produce a hit.
  assign hit  = (state == IDLE) && dp_imemREN && valid[req_idx] &&
                (tag_mem[req_idx] == req_tag);
  assign miss = (state == IDLE) && dp_imemREN && !hit;
  assign fill = (state == FETCH) && !ram_iwait;

  assign dp_ihit     = hit;
  assign dp_imemload = hit ? data_mem[req_idx] : '0;
  assign ram_iREN    = (state == FETCH);
  assign ram_iaddr   = (state == FETCH) ? {miss_waddr, 2'b00} : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      valid      <= '0;
      miss_waddr <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit && (hit_count != '1))
            hit_count <= hit_count + 32'd1;
          if (miss) begin
            miss_waddr <= dp_imemaddr[31:2];
            state      <= FETCH;
            if (miss_count != '1)
              miss_count <= miss_count + 32'd1;
          end
        end
        FETCH: begin
          // Datapath redirects are ignored here; the fill always completes.
          if (!ram_iwait) begin
            valid[miss_idx] <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data storage is not reset; a reset during FETCH suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && fill) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= ram_iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dp_imemREN;
  logic [31:0] dp_imemaddr;
  logic        dp_ihit;
  logic [31:0] dp_imemload;
  logic        ram_iREN;
  logic [31:0] ram_iaddr;
  logic        ram_iwait;
  logic [31:0] ram_iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  icache #(.NSETS(16), .PC_INIT(32'h0)) dut (
    .CLK(CLK), .RST(RST),
    .dp_imemREN(dp_imemREN), .dp_imemaddr(dp_imemaddr),
    .dp_ihit(dp_ihit), .dp_imemload(dp_imemload),
    .ram_iREN(ram_iREN), .ram_iaddr(ram_iaddr),
    .ram_iwait(ram_iwait), .ram_iload(ram_iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  // One record per clock cycle: inputs driven after the falling edge,
  // expected outputs checked before the next rising edge (counters show
  // the value accumulated by previous cycles).
  typedef struct {
    logic        rst;
    logic        ren;
    logic [31:0] addr;
    logic        iwait;
    logic [31:0] iload;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
    logic [31:0] e_hc;
    logic [31:0] e_mc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic ren, input logic [31:0] addr,
                     input logic iwait, input logic [31:0] iload,
                     input logic e_hit, input logic [31:0] e_load,
                     input logic e_iren, input logic [31:0] e_iaddr,
                     input logic [31:0] e_hc, input logic [31:0] e_mc);
    vec_t v;
    v.rst = rst; v.ren = ren; v.addr = addr; v.iwait = iwait; v.iload = iload;
    v.e_hit = e_hit; v.e_load = e_load; v.e_iren = e_iren; v.e_iaddr = e_iaddr;
    v.e_hc = e_hc; v.e_mc = e_mc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge CLK);
    RST = v.rst; dp_imemREN = v.ren; dp_imemaddr = v.addr;
    ram_iwait = v.iwait; ram_iload = v.iload;
    #1;
    chk("dp_ihit",     idx, {31'd0, dp_ihit},  {31'd0, v.e_hit});
    chk("dp_imemload", idx, dp_imemload,       v.e_load);
    chk("ram_iREN",    idx, {31'd0, ram_iREN}, {31'd0, v.e_iren});
    chk("ram_iaddr",   idx, ram_iaddr,         v.e_iaddr);
    chk("hit_count",   idx, hit_count,         v.e_hc);
    chk("miss_count",  idx, miss_count,        v.e_mc);
  endtask

  localparam logic [31:0] W40  = 32'h2001_0005;
  localparam logic [31:0] W80  = 32'h1111_0080;
  localparam logic [31:0] W100 = 32'h3333_0100;
  localparam logic [31:0] W204 = 32'h4444_0204;
  localparam logic [31:0] W308 = 32'h5555_0308;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  initial begin
    RST = 1'b1; dp_imemREN = 1'b0; dp_imemaddr = '0; ram_iwait = 1'b1; ram_iload = JUNK;
    repeat (2) @(posedge CLK);

    // Reset state and idle requests: nothing moves for 10 cycles.
    for (int i = 0; i < 10; i++)
      add(0, 0, 32'h40 + 32'(i * 4), i[0], JUNK, 0, 0, 0, 0, 0, 0);

    // Cold miss on 0x40 with two wait cycles, then hit.
    add(0, 1, 32'h40, 1, JUNK, 0, 0,   0, 0,     0, 0);
    add(0, 1, 32'h40, 1, JUNK, 0, 0,   1, 32'h40, 0, 1);
    add(0, 1, 32'h40, 1, JUNK, 0, 0,   1, 32'h40, 0, 1);
    add(0, 1, 32'h40, 0, W40,  0, 0,   1, 32'h40, 0, 1);
    // Repeat hits on 0x40.
    for (int i = 0; i < 5; i++)
      add(0, 1, 32'h40, 1, JUNK, 1, W40, 0, 0, 32'(i), 1);
    add(0, 0, 32'h40, 1, JUNK, 0, 0,   0, 0,     5, 1);

    // Conflict: 0x80 shares index 0 with 0x40, then 0x40 misses again.
    add(0, 1, 32'h80, 0, JUNK, 0, 0,   0, 0,     5, 1);
    add(0, 1, 32'h80, 0, W80,  0, 0,   1, 32'h80, 5, 2);
    add(0, 1, 32'h80, 1, JUNK, 1, W80, 0, 0,     5, 2);
    add(0, 1, 32'h40, 1, JUNK, 0, 0,   0, 0,     6, 2);
    add(0, 1, 32'h40, 0, W40,  0, 0,   1, 32'h40, 6, 3);
    add(0, 1, 32'h40, 1, JUNK, 1, W40, 0, 0,     6, 3);

    // Redirect during fill of 0x100; 0x204 evaluated afterwards.
    add(0, 1, 32'h100, 1, JUNK, 0, 0,    0, 0,      7, 3);
    add(0, 1, 32'h204, 1, JUNK, 0, 0,    1, 32'h100, 7, 4);
    add(0, 0, 32'h204, 0, W100, 0, 0,    1, 32'h100, 7, 4);
    add(0, 1, 32'h204, 1, JUNK, 0, 0,    0, 0,      7, 4);
    add(0, 1, 32'h204, 0, W204, 0, 0,    1, 32'h204, 7, 5);
    add(0, 1, 32'h204, 1, JUNK, 1, W204, 0, 0,      7, 5);
    add(0, 1, 32'h100, 1, JUNK, 1, W100, 0, 0,      8, 5);
    add(0, 1, 32'h40,  1, JUNK, 0, 0,    0, 0,      9, 5);
    add(0, 1, 32'h40,  0, W40,  0, 0,    1, 32'h40,  9, 6);
    add(0, 0, 32'h40,  1, JUNK, 0, 0,    0, 0,      9, 6);

    // Byte-offset bits ignored; miss address is word aligned.
    add(0, 1, 32'h43,  1, JUNK, 1, W40,  0, 0,      9, 6);
    add(0, 1, 32'h41,  1, JUNK, 1, W40,  0, 0,      10, 6);
    add(0, 1, 32'h30B, 0, JUNK, 0, 0,    0, 0,      11, 6);
    add(0, 1, 32'h30B, 0, W308, 0, 0,    1, 32'h308, 11, 7);
    add(0, 1, 32'h308, 1, JUNK, 1, W308, 0, 0,      11, 7);
    add(0, 0, 32'h308, 1, JUNK, 0, 0,    0, 0,      12, 7);

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset in the second FETCH cycle of a miss on 0x100 (index 0 holds 0x40).
    begin
      vec_t v;
      int base = vecs.size();
      v = '{0, 1, 32'h100, 1, JUNK, 0, 0, 0, 0, 12, 7};          apply(v, base);
      v = '{0, 1, 32'h100, 1, JUNK, 0, 0, 1, 32'h100, 12, 8};    apply(v, base + 1);
      v = '{1, 1, 32'h100, 0, W100, 0, 0, 1, 32'h100, 12, 8};    apply(v, base + 2);
      v = '{0, 0, 32'h100, 0, JUNK, 0, 0, 0, 0, 0, 0};           apply(v, base + 3);
      v = '{0, 1, 32'h40,  1, JUNK, 0, 0, 0, 0, 0, 0};           apply(v, base + 4);
      v = '{0, 1, 32'h100, 0, 32'h0BAD_0100, 0, 0, 1, 32'h40, 0, 1}; apply(v, base + 5);
      v = '{0, 1, 32'h100, 1, JUNK, 0, 0, 0, 0, 0, 1};           apply(v, base + 6);
      v = '{0, 1, 32'h100, 0, W100, 0, 0, 1, 32'h100, 0, 2};     apply(v, base + 7);
      v = '{0, 1, 32'h100, 1, JUNK, 1, W100, 0, 0, 0, 2};        apply(v, base + 8);
      v = '{0, 0, 32'h100, 1, JUNK, 0, 0, 0, 0, 1, 2};           apply(v, base + 9);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
